store_write_ctrl: RTL and testbench
===================================

STORE_WRITE_CTRL -- requirements
Module: store_write_ctrl

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, meaning the number of store-queue entries (power of two, at least 2).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have the port st_valid, input, 1 bit: a store request from the execute stage is present.
REQ-005 The block SHALL have the port st_ready, output, 1 bit: the queue can accept a request this cycle.
REQ-006 The block SHALL have the port st_addr, input, 32 bits: the byte address of the store.
REQ-007 The block SHALL have the port st_data, input, 32 bits: the raw rs2 value.
REQ-008 The block SHALL have the port st_sel, input, 4 bits: the store size, where 4'b0000 = word, 4'b0010 = byte, 4'b0100 = half; any other value is invalid.
REQ-009 The block SHALL have the port mem_req, output, 1 bit: a write to data memory is pending.
REQ-010 The block SHALL have the port mem_addr, output, 32 bits: the word-aligned write address, with [1:0] = 0.
REQ-011 The block SHALL have the port mem_wdata, output, 32 bits: the lane-placed write data.
REQ-012 The block SHALL have the port mem_be, output, 4 bits: the byte enables, where bit i selects byte lane i.
REQ-013 The block SHALL have the port mem_ack, input, 1 bit: memory accepted the current write.
REQ-014 The block SHALL have the port busy, output, 1 bit: the queue is non-empty or a write is in flight.
REQ-015 The block SHALL have the port err, output, 1 bit: a one-cycle pulse when a request is rejected.

Function
REQ-016 st_ready SHALL equal !full, be registered-state based, and not depend combinationally on mem_ack.
REQ-017 A request SHALL be accepted when st_valid && st_ready at a rising edge.
REQ-018 A word request SHALL produce be = 4'b1111 and data = st_data, and is legal only when addr[1:0] = 0.
REQ-019 A half request SHALL produce be = 4'b0011 << (2*addr[1]) and data = {2{st_data[15:0]}}, and is legal only when addr[0] = 0.
REQ-020 A byte request SHALL produce be = 4'b0001 << addr[1:0] and data = {4{st_data[7:0]}}, and is always legal.
REQ-021 An accepted request with an invalid st_sel or a misaligned address SHALL NOT be enqueued, and err SHALL be high for exactly the following cycle.
REQ-022 A legal accepted request SHALL be enqueued as {addr[31:2], be, data}; the write pointer SHALL wrap from DEPTH-1 to 0.
REQ-023 The controller FSM SHALL have two states, IDLE and REQ.
REQ-024 In IDLE, mem_req = 0; the FSM SHALL go to REQ on the edge after which the queue is non-empty.
REQ-025 In REQ, mem_req = 1 and mem_addr/mem_wdata/mem_be SHALL show the head entry and hold stable until mem_ack.
REQ-026 On mem_ack in REQ, the head SHALL be popped (the read pointer wraps at DEPTH); the FSM SHALL stay in REQ with the next entry if one remains, else return to IDLE.
REQ-027 Latency SHALL be as follows: a request accepted into an empty queue at edge N SHALL raise mem_req in the cycle after edge N.
REQ-028 Stores SHALL issue strictly in acceptance order; back-to-back acks SHALL drain one entry per cycle.
REQ-029 Simultaneous enqueue and pop SHALL leave the count unchanged; when full, enqueue SHALL be blocked even if mem_ack is high that cycle.
REQ-030 mem_ack while in IDLE SHALL be ignored.
REQ-031 busy SHALL equal (count != 0) || mem_req.

Reset
REQ-032 When rst_n = 0, the block SHALL asynchronously set FSM = IDLE, pointers = 0, count = 0, mem_req = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, err = 0, busy = 0, st_ready = 1.
REQ-033 A reset asserted mid-transfer SHALL discard all queued stores; no write SHALL be replayed after release.
REQ-034 After rst_n deasserts, the first request SHALL be accepted on the next rising edge.

Structure
REQ-035 A shared package store_pkg SHALL hold the st_sel encodings (SEL_WORD, SEL_BYTE, SEL_HALF), the FSM state enum, and the queue-entry struct.
REQ-036 The queue SHALL be implemented as sub-module store_fifo (parameterised by DEPTH, with count/full/empty outputs); the lane formatting and FSM SHALL stay in store_write_ctrl.

Verification
REQ-037 The bench SHALL cover a byte store: addr = 0x1003, data = 0xAABBCCDD, sel = 4'b0010 -> mem_addr = 0x1000, be = 4'b1000, wdata = 0xDDDDDDDD, with mem_req in the cycle after acceptance.
REQ-038 The bench SHALL cover a half store: addr = 0x2002, data = 0x12345678, sel = 4'b0100 -> be = 4'b1100, wdata = 0x56785678; then addr = 0x2001 with half -> err pulse, nothing enqueued, busy unchanged.
REQ-039 The bench SHALL cover a fill: mem_ack held 0 and 4 word stores -> st_ready = 0 after the 4th; a 5th st_valid is not accepted; after one ack, st_ready = 1 and order is preserved.
REQ-040 The bench SHALL cover draining: 3 queued stores with mem_ack held 1 -> three consecutive writes on consecutive cycles, then IDLE and busy = 0.
REQ-041 The bench SHALL cover reset mid-transfer: rst_n low while mem_req = 1 with 2 entries -> all outputs at reset values immediately, and no write after release.
REQ-042 The bench SHALL cover an invalid size: sel = 4'b0001 -> err pulse, no enqueue; also a stray mem_ack in IDLE -> no state change.

Source files
------------

// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : store_pkg
//  Purpose  : Shared store-size encodings, controller states and queue entry.
//  Revision : 1.0 - initial release
// ============================================================================
package store_pkg;

    localparam logic [3:0] SEL_WORD = 4'b0000;
    localparam logic [3:0] SEL_BYTE = 4'b0010;
    localparam logic [3:0] SEL_HALF = 4'b0100;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic [29:0] addr_hi;
        logic [3:0]  be;
        logic [31:0] data;
    } st_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : store_fifo
//  Purpose  : In-order store queue; pointers wrap naturally (DEPTH is 2^n).
//  Revision : 1.0 - initial release
// ============================================================================
module store_fifo
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  st_entry_t                push_entry,
    input  logic                     pop,
    output st_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_FULL  = DEPTH[c_PTR_W:0];

    st_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only visible while count != 0.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= push_entry;
    end

endmodule
`default_nettype wire

// File: rtl/store_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_ctrl
//  Purpose  : Formats stores into byte lanes, queues them, issues in order.
//  Revision : 1.0 - initial release
// ============================================================================
module store_write_ctrl
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_sel,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_err;
    logic [3:0]          w_be;
    logic [31:0]         w_data;
    logic                w_legal;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;
    st_entry_t           w_entry;
    st_entry_t           w_head;

    always_comb begin
        w_be    = 4'b0000;
        w_data  = st_data;
        w_legal = 1'b0;
        case (st_sel)
            SEL_WORD: begin
                w_be    = 4'b1111;
                w_legal = (st_addr[1:0] == 2'b00);
            end
            SEL_HALF: begin
                w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                w_data  = {2{st_data[15:0]}};
                w_legal = !st_addr[0];
            end
            SEL_BYTE: begin
                w_be    = 4'b0001 << st_addr[1:0];
                w_data  = {4{st_data[7:0]}};
                w_legal = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept = st_valid && !w_full;
    assign w_push   = w_accept && w_legal;
    assign w_entry  = '{addr_hi: st_addr[31:2], be: w_be, data: w_data};

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_entry),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_count),
        .full       (w_full),
        .empty      (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_accept && !w_legal;
        end
    end

    // Entering REQ on the accepting edge gives mem_req one cycle after acceptance.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_push || !w_empty)
                    w_state_next = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    w_pop = 1'b1;
                    if ((w_count == c_CNT_W'(1)) && !w_push)
                        w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign mem_req   = (r_state == REQ);
    assign mem_addr  = mem_req ? {w_head.addr_hi, 2'b00} : 32'h0;
    assign mem_wdata = mem_req ? w_head.data : 32'h0;
    assign mem_be    = mem_req ? w_head.be : 4'b0000;
    assign st_ready  = !w_full;
    assign busy      = (w_count != '0) || mem_req;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_write_ctrl
//  Purpose  : Self-checking bench: vector table plus scoreboard of memory writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_sel;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;
    int n_writes = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[12];

    store_write_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_sel    (st_sel),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            n_writes++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h expected none", mem_addr);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_be", {28'h0, mem_be}, {28'h0, e.be});
                chk("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [3:0] be,
                               input logic [31:0] wd);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_sel   = s;
        sb.push_back('{addr: {a[31:2], 2'b00}, be: be, data: wd});
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h0000_1003, 32'hAABB_CCDD, 4'b0010, 1'b0, 4'b1000, 32'hDDDD_DDDD};
        vecs[1]  = '{32'h0000_2002, 32'h1234_5678, 4'b0100, 1'b0, 4'b1100, 32'h5678_5678};
        vecs[2]  = '{32'h0000_2001, 32'h1234_5678, 4'b0100, 1'b1, 4'b0000, 32'h0};
        vecs[3]  = '{32'h0000_3000, 32'hCAFE_F00D, 4'b0000, 1'b0, 4'b1111, 32'hCAFE_F00D};
        vecs[4]  = '{32'h0000_3002, 32'hCAFE_F00D, 4'b0000, 1'b1, 4'b0000, 32'h0};
        vecs[5]  = '{32'h0000_4000, 32'h1122_3344, 4'b0010, 1'b0, 4'b0001, 32'h4444_4444};
        vecs[6]  = '{32'h0000_4001, 32'h1122_3344, 4'b0010, 1'b0, 4'b0010, 32'h4444_4444};
        vecs[7]  = '{32'h0000_4002, 32'h1122_3344, 4'b0010, 1'b0, 4'b0100, 32'h4444_4444};
        vecs[8]  = '{32'h0000_4000, 32'h1122_3344, 4'b0100, 1'b0, 4'b0011, 32'h3344_3344};
        vecs[9]  = '{32'h0000_4000, 32'h1122_3344, 4'b0001, 1'b1, 4'b0000, 32'h0};
        vecs[10] = '{32'h0000_4000, 32'h1122_3344, 4'b1111, 1'b1, 4'b0000, 32'h0};
        vecs[11] = '{32'h0000_4003, 32'h1122_3344, 4'b0100, 1'b1, 4'b0000, 32'h0};

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = '0; mem_ack = 1'b0;
        #12;
        chk("rst_ready", {31'h0, st_ready}, 32'h1);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single-store vector table
        for (int i = 0; i < 12; i++) begin
            st_valid = 1'b1;
            st_addr  = vecs[i].addr;
            st_data  = vecs[i].data;
            st_sel   = vecs[i].sel;
            if (!vecs[i].exp_err)
                sb.push_back('{addr: {vecs[i].addr[31:2], 2'b00}, be: vecs[i].exp_be,
                               data: vecs[i].exp_wdata});
            step();
            st_valid = 1'b0;
            chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_req", i), {31'h0, mem_req}, {31'h0, !vecs[i].exp_err});
            chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, !vecs[i].exp_err});
            if (!vecs[i].exp_err) begin
                mem_ack = 1'b1;
                step();
                mem_ack = 1'b0;
            end else begin
                step();
            end
            chk($sformatf("v%0d_err_clr", i), {31'h0, err}, 32'h0);
            chk($sformatf("v%0d_idle", i), {31'h0, busy}, 32'h0);
        end

        // Fill to DEPTH with no acks; full blocks enqueue even with ack high
        for (int i = 0; i < 4; i++)
            drive_store(32'h5000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b0000, 4'b1111,
                        32'hA000_0000 + 32'(i));
        chk("fill_ready", {31'h0, st_ready}, 32'h0);
        st_valid = 1'b1; st_addr = 32'h6000; st_data = 32'hDEAD_BEEF; st_sel = 4'b0000;
        step();
        chk("fill_blocked", {31'h0, st_ready}, 32'h0);
        mem_ack = 1'b1;
        step();
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        chk("fill_ready_after_ack", {31'h0, st_ready}, 32'h1);
        mem_ack = 1'b1;
        step(); step(); step();
        mem_ack = 1'b0;
        chk("fill_drained", {31'h0, busy}, 32'h0);

        // Back-to-back drain of three entries
        for (int i = 0; i < 3; i++)
            drive_store(32'h7000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'b0000, 4'b1111,
                        32'hB000_0000 + 32'(i));
        begin
            int w0;
            w0 = n_writes;
            mem_ack = 1'b1;
            step(); step(); step();
            chk("drain_writes", 32'(n_writes - w0), 32'd3);
            chk("drain_idle", {31'h0, mem_req}, 32'h0);
            chk("drain_busy", {31'h0, busy}, 32'h0);
            step();
            chk("stray_ack_idle", {31'h0, mem_req}, 32'h0);
            chk("stray_ack_busy", {31'h0, busy}, 32'h0);
            mem_ack = 1'b0;
        end

        // Reset in the middle of a transfer with two entries queued
        drive_store(32'h8000, 32'h1, 4'b0000, 4'b1111, 32'h1);
        drive_store(32'h8004, 32'h2, 4'b0000, 4'b1111, 32'h2);
        chk("mid_req", {31'h0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_wdata", mem_wdata, 32'h0);
        chk("mid_rst_be", {28'h0, mem_be}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_ready", {31'h0, st_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int w0;
            w0 = n_writes;
            mem_ack = 1'b1;
            step(); step(); step();
            mem_ack = 1'b0;
            chk("no_replay", 32'(n_writes - w0), 32'd0);
            chk("no_replay_req", {31'h0, mem_req}, 32'h0);
        end

        // First request straight after reset release
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_store(32'h9001, 32'h0000_00EE, 4'b0010, 4'b0010, 32'hEEEE_EEEE);
        chk("post_rst_req", {31'h0, mem_req}, 32'h1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
